// File: rtl/pwm_multi.sv
// Multi-channel PWM sharing one period counter; settings go through shadow registers
// and are applied only at a period boundary so no output period is ever truncated.
module pwm_multi #(
  parameter int CLK_FREQ_HZ = 25000000,
  parameter int CHANNELS    = 4,
  parameter int WIDTH       = 16,
  parameter int CNT_WIDTH   = 24
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          period_usec,
  input  logic [CHANNELS*WIDTH-1:0] duty_usec,
  input  logic [CHANNELS-1:0]       invert,
  input  logic                      upd_valid,
  output logic                      upd_ready,
  output logic                      period_start,
  output logic [CHANNELS-1:0]       pin
);
  localparam int CYCLES_PER_USEC = CLK_FREQ_HZ / 1000000;
  localparam longint MAX_CYC = ((longint'(1) << WIDTH) - 1) * longint'(CYCLES_PER_USEC);
  localparam logic [CNT_WIDTH-1:0] CYC = CNT_WIDTH'(CYCLES_PER_USEC);

  if (CYCLES_PER_USEC < 1 || (CLK_FREQ_HZ % 1000000) != 0) begin : g_bad_clk
    $error("pwm_multi: CLK_FREQ_HZ must be a nonzero multiple of 1 MHz");
  end
  if (CHANNELS < 1) begin : g_bad_channels
    $error("pwm_multi: CHANNELS must be at least 1");
  end
  if (CNT_WIDTH < 63 && MAX_CYC > ((longint'(1) << CNT_WIDTH) - 1)) begin : g_bad_cnt
    $error("pwm_multi: CNT_WIDTH too small for the largest period");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t                 state;
  logic                   pending;
  logic [CNT_WIDTH-1:0]   cnt;
  logic [CNT_WIDTH-1:0]   act_period, sh_period;
  logic [CNT_WIDTH-1:0]   act_duty [CHANNELS];
  logic [CNT_WIDTH-1:0]   sh_duty  [CHANNELS];
  logic [CHANNELS-1:0]    act_inv, sh_inv;

  logic                   accept, wrap, boundary, apply, nxt_run;
  logic [CNT_WIDTH-1:0]   req_period, nxt_period, nxt_cnt;
  logic [CNT_WIDTH-1:0]   req_duty [CHANNELS];
  logic [CNT_WIDTH-1:0]   nxt_duty [CHANNELS];
  logic [CHANNELS-1:0]    nxt_inv, nxt_pin;

  // Scale to cycles at acceptance so the period logic only ever compares counts.
  always_comb begin
    req_period = CNT_WIDTH'(period_usec) * CYC;
    for (int i = 0; i < CHANNELS; i++) begin
      req_duty[i] = CNT_WIDTH'(duty_usec[i*WIDTH +: WIDTH]) * CYC;
      if (req_duty[i] > req_period) req_duty[i] = req_period;
    end
  end

  assign accept   = upd_valid & upd_ready;
  assign wrap     = (state == RUN) && (cnt == act_period - CNT_WIDTH'(1));
  assign boundary = wrap || ((state == IDLE) && pending);
  assign apply    = boundary && pending;

  // Outputs are computed from next-cycle state so the registered pins line up with cnt.
  always_comb begin
    nxt_period = act_period;
    nxt_inv    = act_inv;
    nxt_run    = (state == RUN);
    for (int i = 0; i < CHANNELS; i++) nxt_duty[i] = act_duty[i];
    if (apply) begin
      nxt_period = sh_period;
      nxt_inv    = sh_inv;
      nxt_run    = (sh_period != '0);
      for (int i = 0; i < CHANNELS; i++) nxt_duty[i] = sh_duty[i];
    end
    nxt_cnt = (boundary || !nxt_run) ? '0 : cnt + CNT_WIDTH'(1);
    for (int i = 0; i < CHANNELS; i++)
      nxt_pin[i] = (nxt_run && (nxt_cnt < nxt_duty[i])) ^ nxt_inv[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      pending      <= 1'b0;
      cnt          <= '0;
      act_period   <= '0;
      sh_period    <= '0;
      act_inv      <= '0;
      sh_inv       <= '0;
      upd_ready    <= 1'b1;
      period_start <= 1'b0;
      pin          <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        act_duty[i] <= '0;
        sh_duty[i]  <= '0;
      end
    end else begin
      state      <= nxt_run ? RUN : IDLE;
      cnt        <= nxt_cnt;
      act_period <= nxt_period;
      act_inv    <= nxt_inv;
      for (int i = 0; i < CHANNELS; i++) act_duty[i] <= nxt_duty[i];
      if (accept) begin
        sh_period <= req_period;
        sh_inv    <= invert;
        for (int i = 0; i < CHANNELS; i++) sh_duty[i] <= req_duty[i];
      end
      pending <= accept | (pending & ~apply);
      // Ready stays low through the cycle in which the applied values first show.
      upd_ready    <= ~accept & ~pending;
      period_start <= nxt_run && (nxt_cnt == '0);
      pin          <= nxt_pin;
    end
  end
endmodule

// File: tb/tb_pwm_multi.sv
// Bench for pwm_multi at 4 cycles/usec: directed scenarios plus random updates,
// every cycle compared against a frame-level reference model.
module tb_pwm_multi;
  localparam int CH  = 4;
  localparam int W   = 16;
  localparam int CPU = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [W-1:0]    period_usec = '0;
  logic [CH*W-1:0] duty_usec = '0;
  logic [CH-1:0]   invert = '0;
  logic            upd_valid = 1'b0;
  logic            upd_ready, period_start;
  logic [CH-1:0]   pin;

  int tests = 0;
  int fails = 0;

  // Reference model: active frame, phase within frame, and one pending update.
  int       m_p, m_k, s_p;
  int       m_d [CH];
  int       s_d [CH];
  bit [3:0] m_inv, s_inv, m_pin;
  bit       m_run, m_pend, m_rdy, m_ps;

  pwm_multi #(.CLK_FREQ_HZ(4000000), .CHANNELS(CH), .WIDTH(W), .CNT_WIDTH(24)) dut (
    .clk(clk), .rst(rst), .period_usec(period_usec), .duty_usec(duty_usec),
    .invert(invert), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .period_start(period_start), .pin(pin)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit acc, old_pend, bnd;
    if (rst) begin
      m_p = 0; m_k = 0; m_inv = '0; m_run = 0; m_pend = 0;
      for (int i = 0; i < CH; i++) m_d[i] = 0;
      m_rdy = 1; m_ps = 0; m_pin = '0;
      return;
    end
    acc      = upd_valid && m_rdy;
    old_pend = m_pend;
    if (m_run) begin
      m_k++;
      bnd = (m_k == m_p);
      if (bnd) m_k = 0;
    end else bnd = m_pend;
    if (bnd && m_pend) begin
      m_p = s_p; m_inv = s_inv; m_d = s_d;
      m_pend = 0; m_run = (m_p != 0); m_k = 0;
    end
    if (acc) begin
      s_p = int'(period_usec) * CPU;
      for (int i = 0; i < CH; i++) begin
        s_d[i] = int'(duty_usec[i*W +: W]) * CPU;
        if (s_d[i] > s_p) s_d[i] = s_p;
      end
      s_inv = invert; m_pend = 1;
    end
    m_rdy = !m_pend && !old_pend;
    m_ps  = m_run && (m_k == 0);
    for (int i = 0; i < CH; i++) m_pin[i] = m_run ? ((m_k < m_d[i]) ^ m_inv[i]) : m_inv[i];
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("pin", 32'(pin), 32'(m_pin));
    chk("period_start", 32'(period_start), 32'(m_ps));
    chk("upd_ready", 32'(upd_ready), 32'(m_rdy));
  endtask

  task automatic drive(input int p, input int d0, input int d1, input int d2, input int d3,
                       input logic [3:0] inv, input logic v);
    period_usec = W'(p);
    duty_usec   = {W'(d3), W'(d2), W'(d1), W'(d0)};
    invert      = inv;
    upd_valid   = v;
  endtask

  task automatic wait_ps();
    int n = 0;
    while (period_start !== 1'b1 && n < 400) begin
      step();
      n++;
    end
    chk("wait_period_start", 32'(period_start), 32'd1);
  endtask

  // Measures one frame of n cycles starting at a period_start and checks per-channel active counts.
  task automatic expect_period(input string tag, input int n, input int e0, input int e1,
                               input int e2, input int e3);
    int c0, c1, c2, c3, cps;
    wait_ps();
    c0 = int'(pin[0]); c1 = int'(pin[1]); c2 = int'(pin[2]); c3 = int'(pin[3]);
    cps = int'(period_start);
    for (int j = 1; j < n; j++) begin
      step();
      c0 += int'(pin[0]); c1 += int'(pin[1]); c2 += int'(pin[2]); c3 += int'(pin[3]);
      cps += int'(period_start);
    end
    chk({tag, "_ch0"}, c0, e0);
    chk({tag, "_ch1"}, c1, e1);
    chk({tag, "_ch2"}, c2, e2);
    chk({tag, "_ch3"}, c3, e3);
    chk({tag, "_starts"}, cps, 1);
  endtask

  initial begin
    int n, c0, cps, bad;
    bit acc;

    // Reset and idle
    rst = 1'b1;
    step(); step();
    chk("reset_pin", 32'(pin), 0);
    chk("reset_period_start", 32'(period_start), 0);
    chk("reset_upd_ready", 32'(upd_ready), 1);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step();

    // Basic update: 5us period, mixed duties, ch3 inverted
    drive(5, 2, 0, 7, 1, 4'b1000, 1'b1);
    step();
    upd_valid = 1'b0;
    n = 0;
    while (upd_ready === 1'b0 && n < 20) begin
      n++;
      step();
    end
    chk("ready_low_cycles", n, 2);
    expect_period("basic", 20, 8, 0, 20, 16);

    // Mid-period duty change; conflicting data held while not ready must be ignored
    wait_ps();
    c0 = int'(pin[0]);
    for (int j = 1; j < 20; j++) begin
      if (j == 5)  drive(5, 4, 0, 7, 1, 4'b1000, 1'b1);
      if (j == 6)  drive(3, 1, 1, 1, 1, 4'b0000, 1'b1);
      if (j == 19) upd_valid = 1'b0;
      step();
      c0 += int'(pin[0]);
    end
    chk("midupd_old_ch0", c0, 8);
    expect_period("midupd_new", 20, 16, 0, 20, 16);
    expect_period("midupd_again", 20, 16, 0, 20, 16);

    // Period 0 stops the PWM after the current frame
    drive(0, 0, 0, 0, 0, 4'b1000, 1'b1);
    step();
    upd_valid = 1'b0;
    for (int i = 0; i < 45; i++) step();
    cps = 0; bad = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      cps += int'(period_start);
      if (pin !== 4'b1000) bad++;
    end
    chk("stopped_starts", cps, 0);
    chk("stopped_pin_not_inactive", bad, 0);

    // Restart from idle with a 1us period
    drive(1, 1, 0, 2, 0, 4'b0000, 1'b1);
    step();
    upd_valid = 1'b0;
    n = 0;
    while (period_start !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    chk("restart_latency", n, 1);
    expect_period("restart", 4, 4, 0, 4, 0);

    // Acceptance exactly on the wrap edge defers by one full frame
    wait_ps();
    step(); step(); step();
    drive(2, 1, 0, 0, 0, 4'b0000, 1'b1);
    step();
    upd_valid = 1'b0;
    chk("wrap_accept_start", 32'(period_start), 1);
    n = 0;
    while (upd_ready === 1'b0 && n < 50) begin
      n++;
      step();
    end
    chk("wrap_ready_low_cycles", n, 5);
    expect_period("wrap_new", 8, 4, 0, 0, 0);

    // Reset with an update pending discards it
    wait_ps();
    step(); step(); step();
    drive(3, 3, 3, 3, 3, 4'b1111, 1'b1);
    step();
    upd_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_pin", 32'(pin), 0);
    chk("midrst_period_start", 32'(period_start), 0);
    chk("midrst_upd_ready", 32'(upd_ready), 1);
    cps = 0; bad = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      cps += int'(period_start);
      if (pin !== 4'b0000) bad++;
    end
    chk("midrst_starts", cps, 0);
    chk("midrst_pin_active", bad, 0);

    // Random updates against the model
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(19) == 0) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
      end
      drive($urandom_range(6), $urandom_range(8), $urandom_range(8), $urandom_range(8),
            $urandom_range(8), 4'($urandom_range(15)), 1'b1);
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) step();
      upd_valid = 1'b0;
      n = $urandom_range(0, 30);
      for (int i = 0; i < n; i++) step();
    end

    // Maximum period and duty: constantly active, no spurious frame start
    drive(65535, 65535, 65535, 65535, 65535, 4'b0000, 1'b1);
    n = 0;
    acc = 1'b0;
    while (!acc && n < 200) begin
      acc = m_rdy;
      step();
      n++;
    end
    upd_valid = 1'b0;
    step();
    wait_ps();
    cps = 0; bad = 0;
    for (int i = 0; i < 3000; i++) begin
      step();
      cps += int'(period_start);
      if (pin !== 4'b1111) bad++;
    end
    chk("max_starts", cps, 0);
    chk("max_pin_gaps", bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
Multi-channel PWM generator and the parametrised successor of the single-channel usec PWM. All CHANNELS outputs share one period counter, and each channel has its own duty and polarity. New settings arrive through a valid/ready handshake into shadow registers. They take effect only at a period boundary, so no output ever shows a glitched or truncated period. A period_start pulse lets downstream logic (ADC trigger, LED mux) synchronise to the PWM frame.

Parameters:
CLK_FREQ_HZ, 25000000, main clock frequency; CYCLES_PER_USEC = CLK_FREQ_HZ/1000000, must be an integer >= 1 (elaboration error otherwise)
CHANNELS, 4, number of PWM outputs, >= 1
WIDTH, 16, width of the period and duty fields in usec
CNT_WIDTH, 24, internal cycle counter width; elaboration error if 2^WIDTH-1 times CYCLES_PER_USEC does not fit

Ports:
clk  input  1  main clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
period_usec  input  WIDTH  requested shared period in usec
duty_usec  input  CHANNELS*WIDTH  requested duty per channel; channel i in bits [i*WIDTH +: WIDTH]
invert  input  CHANNELS  requested polarity per channel; 1 = active-low output
upd_valid  input  1  request to load period_usec, duty_usec and invert
upd_ready  output  1  block can accept an update
period_start  output  1  one-cycle pulse in the first cycle of every period
pin  output  CHANNELS  PWM outputs, registered

Behaviour:
- Reset (rst=1 at an edge), applied next cycle:
  - active period = 0, all active duty = 0, active invert = 0
  - no pending update, cnt = 0
  - pin = 0, period_start = 0, upd_ready = 1
- Reset mid-operation discards any pending update.
- Arithmetic:
  - period_cyc = period_usec * CYCLES_PER_USEC, duty_cyc[i] = duty_usec[i] * CYCLES_PER_USEC, both computed at CNT_WIDTH.
  - Multiplication is done when the update is accepted, so the shadow registers hold cycle counts.
  - duty_cyc >= period_cyc saturates to period_cyc (100% active).
- Handshake:
  - Update accepted on an edge with upd_valid & upd_ready; period, duty and invert are captured into shadow registers.
  - pending is set and upd_ready drops the next cycle.
  - upd_ready returns to 1 in the cycle after the pending update is applied; at most one update can be pending.
  - Inputs are ignored while upd_ready = 0.
- State IDLE (active period_cyc = 0):
  - cnt holds 0, period_start = 0, pin[i] = invert[i] (inactive level).
  - A pending update is applied at the next edge. If the new period is nonzero, go to RUN with the first period starting in the cycle after that edge.
- State RUN:
  - cnt counts 0 .. period_cyc-1 and wraps to 0.
  - The boundary is the edge at which cnt loads 0, whether by wrap or by entry from IDLE.
  - At a boundary, a pending update is copied to the active registers, and the new values govern that entire period.
  - If the applied period is 0, go to IDLE at that boundary and drive pins inactive from the next cycle.
- Outputs in RUN:
  - period_start = 1 exactly in cycles where cnt = 0.
  - pin[i] = (cnt < duty_cyc[i]) XOR invert[i], registered so it is aligned with cnt.
  - Each channel is therefore active for exactly duty_cyc[i] cycles per period, starting in the period_start cycle.
- Duty edge cases:
  - duty 0: pin is constantly inactive and never pulses.
  - Saturated duty: pin is constantly active, with no one-cycle gap at the wrap.
  - period_cyc = 1: period_start is constantly 1; pin is active iff duty > 0.
- Simultaneous events:
  - Acceptance on the same edge as a boundary does not apply that update; it applies at the following boundary.
  - rst wins over everything.
- Latency from acceptance to effect: up to one full period plus one cycle.

Test Plan:
All scenarios use CLK_FREQ_HZ=4000000 (4 cycles/usec), CHANNELS=4, WIDTH=16, CNT_WIDTH=24.

- Reset, then an update with period=5us, duty={ch0 2, ch1 0, ch2 7, ch3 1}, invert=4'b1000:
  - period_start pulses every 20 cycles.
  - ch0 is high 8 of 20 cycles, ch1 is constantly 0, ch2 is constantly 1.
  - ch3 is low for 4 cycles then high for 16.
  - upd_ready is low for exactly 2 cycles.
- While running, update to duty ch0 = 4us mid-period:
  - The current period keeps 8 active cycles; the next period starts 16 active cycles in the period_start cycle.
  - No short or long pulse appears.
  - upd_valid held during upd_ready=0 with different data has no effect.
- Update to period=0:
  - After the current period completes, all pins go to their inactive level (ch3=1) and period_start stops.
  - A following update with period=1us restarts within 2 cycles of acceptance.
- Update accepted on the exact wrap edge:
  - It is not applied at that boundary; it applies one full period later.
  - upd_ready stays low throughout.
- rst asserted mid-period with an update pending:
  - The next cycle shows pin=0, period_start=0, upd_ready=1.
  - The pending update is lost, and no PWM activity occurs without a new update.
- Maximum values period=65535us, duty=65535us:
  - No overflow; cnt reaches 262139 and wraps.
  - pin is constantly active.
